// File: rtl/apb_arbiter.sv
// apb_arbiter
//   Shares one downstream APB slave port between NUM_M APB requesters.
//   Round-robin arbitration, one granted transfer at a time; the arbiter
//   regenerates SETUP/ACCESS downstream and routes the completion back to
//   the granted requester only.
//
// Parameters
//   NUM_M    number of requesters (>= 2)
//   TIMEOUT  ACCESS-phase cycle limit (only with APB_ARB_TIMEOUT_EN)
//
// Build option
//   APB_ARB_TIMEOUT_EN  when defined, an ACCESS phase that reaches
//                       TIMEOUT-1 counted cycles without out_pready is
//                       force-completed with an error to the requester.
//
// Ports
//   clock, reset        posedge clock, synchronous active-high reset
//   in_*   (NUM_M)      requester-side APB slots, slot i at [W*i +: W]
//                       (in_penable is ignored)
//   out_*               downstream APB master port
module apb_arbiter #(
   parameter int unsigned NUM_M   = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_M*32-1:0]   in_paddr,
   input  logic [NUM_M-1:0]      in_psel,
   input  logic [NUM_M-1:0]      in_penable,
   input  logic [NUM_M*3-1:0]    in_pprot,
   input  logic [NUM_M-1:0]      in_pwrite,
   input  logic [NUM_M*32-1:0]   in_pwdata,
   input  logic [NUM_M*4-1:0]    in_pstrb,
   output logic [NUM_M-1:0]      in_pready,
   output logic [NUM_M*32-1:0]   in_prdata,
   output logic [NUM_M-1:0]      in_pslverr,
   output logic [31:0]           out_paddr,
   output logic                  out_psel,
   output logic                  out_penable,
   output logic [2:0]            out_pprot,
   output logic                  out_pwrite,
   output logic [31:0]           out_pwdata,
   output logic [3:0]            out_pstrb,
   input  logic                  out_pready,
   input  logic [31:0]           out_prdata,
   input  logic                  out_pslverr
);

   localparam int unsigned GW = $clog2(NUM_M);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [GW-1:0] gnt_q, gnt_d;
   logic [GW-1:0] last_q, last_d;

   logic [GW-1:0] pick;
   logic [GW-1:0] cand;
   logic          pick_found;
   logic          busy;
   logic          done;
   logic          timeout_hit;

   logic [31:0]   paddr_a  [NUM_M];
   logic [31:0]   pwdata_a [NUM_M];
   logic [2:0]    pprot_a  [NUM_M];
   logic [3:0]    pstrb_a  [NUM_M];
   logic [31:0]   prdata_a [NUM_M];

   for (genvar i = 0; i < NUM_M; i++) begin : g_slot
      assign paddr_a[i]             = in_paddr[32*i +: 32];
      assign pwdata_a[i]            = in_pwdata[32*i +: 32];
      assign pprot_a[i]             = in_pprot[3*i +: 3];
      assign pstrb_a[i]             = in_pstrb[4*i +: 4];
      assign in_prdata[32*i +: 32]  = prdata_a[i];
   end

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_found = 1'b0;
      for (int unsigned i = 1; i <= NUM_M; i++) begin
         cand = GW'((32'(last_q) + i) % NUM_M);
         if (!pick_found && in_psel[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   logic [31:0] tcnt_q, tcnt_d;
   logic        unused_penable;

   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == S_SETUP) begin
         tcnt_d = '0;
      end else if (state_q == S_ACCESS) begin
         tcnt_d = tcnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

   // A real pready in the same cycle takes precedence over the forced error.
   assign timeout_hit    = (state_q == S_ACCESS) && !out_pready &&
                           (tcnt_q == 32'(TIMEOUT - 1));
   assign unused_penable = ^in_penable;
`else
   logic unused_cfg;
   assign timeout_hit = 1'b0;
   assign unused_cfg  = ^{in_penable, 32'(TIMEOUT)};
`endif

   // Outputs are gated by reset so a transfer aborted by reset never
   // signals completion, even in the cycle reset is sampled.
   assign busy = !reset && ((state_q == S_SETUP) || (state_q == S_ACCESS));
   assign done = !reset && (state_q == S_ACCESS) && (out_pready || timeout_hit);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               gnt_d   = pick;
               state_d = S_SETUP;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (done) begin
               last_d  = gnt_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         last_q  <= GW'(NUM_M - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      out_psel    = busy;
      out_penable = busy && (state_q == S_ACCESS);
      out_paddr   = busy ? paddr_a[gnt_q]  : '0;
      out_pwdata  = busy ? pwdata_a[gnt_q] : '0;
      out_pprot   = busy ? pprot_a[gnt_q]  : '0;
      out_pstrb   = busy ? pstrb_a[gnt_q]  : '0;
      out_pwrite  = busy ? in_pwrite[gnt_q] : 1'b0;
   end

   always_comb begin
      in_pready  = '0;
      in_pslverr = '0;
      prdata_a   = '{default: '0};
      if (done) begin
         in_pready[gnt_q] = 1'b1;
         if (out_pready) begin
            prdata_a[gnt_q]   = out_prdata;
            in_pslverr[gnt_q] = out_pslverr;
         end else begin
            in_pslverr[gnt_q] = 1'b1;
         end
      end
   end

endmodule

// File: doc/apb_arbiter.md
Name:
apb_arbiter

Overview:
- Shares one APB slave port (e.g. the apb_delayer input) between NUM_M APB requesters, with round-robin arbitration and one granted transfer at a time.
- The arbiter regenerates the SETUP/ACCESS phases downstream and returns pready/prdata/pslverr only to the granted requester.

Parameters:
NUM_M, 2, number of requesters (>=2); grant index width is $clog2(NUM_M)
TIMEOUT, 1024, ACCESS-phase cycle limit; used only with APB_ARB_TIMEOUT_EN (>=2)

Ports:
clock  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
in_paddr  in  NUM_M*32  requester i address at bits [32i+31:32i]
in_psel  in  NUM_M  requester select (request)
in_penable  in  NUM_M  requester enable; ignored, the arbiter generates its own
in_pprot  in  NUM_M*3  protection
in_pwrite  in  NUM_M  write flag
in_pwdata  in  NUM_M*32  write data
in_pstrb  in  NUM_M*4  byte strobes
in_pready  out  NUM_M  completion, granted slot only
in_prdata  out  NUM_M*32  read data, granted slot only, else 0
in_pslverr  out  NUM_M  error, granted slot only, else 0
out_paddr  out  32  granted address (0 in IDLE)
out_psel  out  1  downstream select
out_penable  out  1  downstream enable
out_pprot  out  3  granted pprot (0 in IDLE)
out_pwrite  out  1  granted pwrite (0 in IDLE)
out_pwdata  out  32  granted pwdata (0 in IDLE)
out_pstrb  out  4  granted pstrb (0 in IDLE)
out_pready  in  1  downstream ready
out_prdata  in  32  downstream read data
out_pslverr  in  1  downstream error

Behaviour:
- Registers: state {IDLE, SETUP, ACCESS}, gnt (granted index), last (last granted index).
- Reset: state=IDLE, gnt=0, last=NUM_M-1, so requester 0 wins first. All out_* and in_* outputs are 0.
- Reset asserted mid-transfer aborts the transfer immediately, with no pready to anyone.
- IDLE: if any in_psel is high, gnt <= first set psel searching (last+1) mod NUM_M upward with wrap-around; state <= SETUP. Otherwise stay in IDLE.
- SETUP: out_psel=1, out_penable=0; state <= ACCESS unconditionally.
- ACCESS: out_psel=1, out_penable=1.
  - When out_pready=1: in_pready[gnt]=1 and in_prdata/in_pslverr slot gnt = out_prdata/out_pslverr, combinationally in the same cycle; last <= gnt; state <= IDLE.
  - Otherwise wait; there is no limit unless the optional feature is enabled.
- SETUP and ACCESS drive out_paddr/pprot/pwrite/pwdata/pstrb from slot gnt.
- Latency: request sampled in IDLE at cycle c → SETUP at c+1 → ACCESS at c+2. Minimum 3 cycles per transfer, with one mandatory IDLE bubble between transfers.
- Grant is held for the whole transfer. If the granted in_psel drops mid-transfer (a protocol violation), it is ignored and the transfer completes normally.
- Simultaneous requests: exactly one grant per arbitration. A requester that re-asserts psel right after completion loses to any other pending requester.
- Non-granted requesters see in_pready=0 and hold their requests.

Optional Feature:
- APB_ARB_TIMEOUT_EN defined: a 32-bit counter clears on SETUP and increments each ACCESS cycle. If it reaches TIMEOUT-1 without out_pready, the arbiter forces completion: in_pready[gnt]=1, in_pslverr[gnt]=1, in_prdata=0; last <= gnt; state <= IDLE. Any late out_pready is ignored.
- Not defined: no counter; ACCESS waits indefinitely.

Test Plan:
- Single read: psel[0]=1, addr 0x1000_0004, slave ready after 2 ACCESS cycles with prdata 0xDEADBEEF → out_psel rises at c+1, out_penable at c+2; in_pready[0] pulses once with in_prdata[31:0]=0xDEADBEEF; in_pready[1]=0.
- Contention: psel[0]=psel[1]=1 held for 4 transfers, zero-wait slave → grant order 0,1,0,1, each transfer 3 cycles.
- Write: psel[1]=1, pwrite=1, pwdata 0x55AA_55AA, pstrb 0x3 → out_pwdata=0x55AA55AA and out_pstrb=0x3 during SETUP/ACCESS; out_* return to 0 in IDLE.
- Error plus reset mid-transfer: slave returns pslverr=1 → in_pslverr[gnt]=1 for one cycle. Reset in ACCESS → next cycle IDLE, all outputs 0, no pready.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=8, slave never ready → in_pready=1 and in_pslverr=1 exactly 8 ACCESS cycles after SETUP; the other requester is granted next.
